// File: rtl/pixel_readout_ctrl_pkg.sv
// Shared types and constants for the pixel frame sequencer.
package pixel_ro_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      EXPOSE,
      SETTLE,
      SHIFT,
      OUTPUT,
      DONE
   } ro_state_t;

   localparam int CLR_CYCLES    = 2;
   localparam int SETTLE_CYCLES = 2;
   // wide enough for both CLEAR and SETTLE phase counts
   localparam int PH_BITS       = 2;

   // index width with a floor of one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_readout_ctrl_if.sv
// Frame request, array control and readout word port of the pixel sequencer.
interface pixel_readout_ctrl_if
   import pixel_ro_pkg::*;
#(
   parameter int Row      = 2,
   parameter int Col      = 2,
   parameter int CntBits  = 12,
   parameter int ExpWidth = 16
);
   localparam int RowW = cnt_width(Row);

   logic                   start;
   logic                   sumModeCfg;
   logic [ExpWidth-1:0]    expCycles;
   logic                   busy;
   logic                   feReset;
   logic                   shutter;
   logic                   sumMode;
   logic                   shiftEn;
   logic [Col-1:0]         serInA;
   logic [Col-1:0]         serInB;
   logic [Col-1:0]         serOutA;
   logic [Col-1:0]         serOutB;
   logic                   dataValid;
   logic                   dataReady;
   logic [RowW-1:0]        dataRow;
   logic [Col*CntBits-1:0] dataA;
   logic [Col*CntBits-1:0] dataB;
   logic                   frameDone;

   // the sequencer side
   modport master (
      input  start, sumModeCfg, expCycles, serOutA, serOutB, dataReady,
      output busy, feReset, shutter, sumMode, shiftEn, serInA, serInB,
             dataValid, dataRow, dataA, dataB, frameDone
   );

   // the config/readout logic plus the pixel array
   modport slave (
      output start, sumModeCfg, expCycles, serOutA, serOutB, dataReady,
      input  busy, feReset, shutter, sumMode, shiftEn, serInA, serInB,
             dataValid, dataRow, dataA, dataB, frameDone
   );

endinterface

// File: rtl/pixel_readout_ctrl_col_deser.sv
// Serial-to-parallel shift register for one column chain; MSB arrives first.
module col_deser #(
   parameter int CntBits = 12
) (
   input  logic               readClk,
   input  logic               reset,
   input  logic               i_en,
   input  logic               i_bit,
   output logic [CntBits-1:0] o_word
);

   logic [CntBits-1:0] r_sr;

   // shift one bit in on every enabled edge
   always_ff @(posedge readClk) begin
      if (reset) begin
         r_sr <= '0;
      end else if (i_en) begin
         r_sr <= {r_sr[CntBits-2:0], i_bit};
      end
   end

   assign o_word = r_sr;

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer: clear, expose, settle, then read chains A/B row by row.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; latches sumModeCfg and expCycles
//  CLEAR  | feReset high for CLR_CYCLES cycles
//  EXPOSE | shutter high for N cycles (N = expCycles, 0 treated as 1)
//  SETTLE | all controls low for SETTLE_CYCLES cycles
//  SHIFT  | shiftEn high, CntBits bits shifted into every column word
//  OUTPUT | row word presented; waits for dataReady
//  DONE   | one-cycle frameDone pulse
module pixel_readout_ctrl
   import pixel_ro_pkg::*;
#(
   parameter int Row      = 2,
   parameter int Col      = 2,
   parameter int CntBits  = 12,
   parameter int ExpWidth = 16
) (
   input  logic                 readClk,
   input  logic                 reset,
   pixel_readout_ctrl_if.master bus
);

   localparam int RowW = cnt_width(Row);
   localparam int BitW = cnt_width(CntBits);

   ro_state_t              r_state;
   logic [PH_BITS-1:0]     r_phCnt;
   logic [ExpWidth-1:0]    r_expCnt;
   logic [ExpWidth-1:0]    r_expN;
   logic [BitW-1:0]        r_bitCnt;
   logic [RowW-1:0]        r_rowCnt;
   logic                   r_sumMode;

   logic                   w_shift;
   logic [CntBits-1:0]     w_wordA [Col];
   logic [CntBits-1:0]     w_wordB [Col];
   logic [Col*CntBits-1:0] w_dataA;
   logic [Col*CntBits-1:0] w_dataB;

   // frame sequencing and phase/exposure/bit/row counters
   always_ff @(posedge readClk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_phCnt   <= '0;
         r_expCnt  <= '0;
         r_expN    <= '0;
         r_bitCnt  <= '0;
         r_rowCnt  <= '0;
         r_sumMode <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_sumMode <= bus.sumModeCfg;
                  r_expN    <= (bus.expCycles == '0) ? ExpWidth'(1) : bus.expCycles;
                  r_phCnt   <= '0;
                  r_state   <= CLEAR;
               end
            end
            CLEAR: begin
               if (r_phCnt == PH_BITS'(CLR_CYCLES - 1)) begin
                  r_expCnt <= ExpWidth'(1);
                  r_state  <= EXPOSE;
               end else begin
                  r_phCnt <= r_phCnt + 1'b1;
               end
            end
            EXPOSE: begin
               if (r_expCnt == r_expN) begin
                  r_phCnt <= '0;
                  r_state <= SETTLE;
               end else begin
                  r_expCnt <= r_expCnt + 1'b1;
               end
            end
            SETTLE: begin
               if (r_phCnt == PH_BITS'(SETTLE_CYCLES - 1)) begin
                  r_bitCnt <= '0;
                  r_rowCnt <= '0;
                  r_state  <= SHIFT;
               end else begin
                  r_phCnt <= r_phCnt + 1'b1;
               end
            end
            SHIFT: begin
               if (r_bitCnt == BitW'(CntBits - 1)) begin
                  r_state <= OUTPUT;
               end else begin
                  r_bitCnt <= r_bitCnt + 1'b1;
               end
            end
            OUTPUT: begin
               if (bus.dataReady) begin
                  if (r_rowCnt == RowW'(Row - 1)) begin
                     r_state <= DONE;
                  end else begin
                     r_rowCnt <= r_rowCnt + 1'b1;
                     r_bitCnt <= '0;
                     r_state  <= SHIFT;
                  end
               end
            end
            DONE: begin
               r_rowCnt <= '0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_shift = (r_state == SHIFT);

   for (genvar c = 0; c < Col; c++) begin : g_col
      col_deser #(.CntBits(CntBits)) u_deser_a (
         .readClk (readClk),
         .reset   (reset),
         .i_en    (w_shift),
         .i_bit   (bus.serOutA[c]),
         .o_word  (w_wordA[c])
      );
      col_deser #(.CntBits(CntBits)) u_deser_b (
         .readClk (readClk),
         .reset   (reset),
         .i_en    (w_shift),
         .i_bit   (bus.serOutB[c]),
         .o_word  (w_wordB[c])
      );
   end

   // pack per-column words, column c at bits [c*CntBits +: CntBits]
   always_comb begin
      w_dataA = '0;
      w_dataB = '0;
      for (int c = 0; c < Col; c++) begin
         w_dataA[c*CntBits +: CntBits] = w_wordA[c];
         w_dataB[c*CntBits +: CntBits] = w_wordB[c];
      end
   end

   assign bus.busy      = (r_state != IDLE);
   assign bus.feReset   = (r_state == CLEAR);
   assign bus.shutter   = (r_state == EXPOSE);
   assign bus.shiftEn   = w_shift;
   assign bus.dataValid = (r_state == OUTPUT);
   assign bus.frameDone = (r_state == DONE);
   assign bus.sumMode   = r_sumMode;
   assign bus.dataRow   = r_rowCnt;
   assign bus.dataA     = w_dataA;
   assign bus.dataB     = w_dataB;
   // the chains are refilled with zeros as they are read out
   assign bus.serInA    = '0;
   assign bus.serInB    = '0;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Bench for pixel_readout_ctrl: behavioural pixel chains gated by shiftEn,
// a word scoreboard fed from the pixel values loaded into the chains.
module tb_pixel_readout_ctrl;

   localparam int Row      = 2;
   localparam int Col      = 2;
   localparam int CntBits  = 12;
   localparam int ExpWidth = 16;
   localparam int RowW     = (Row > 1) ? $clog2(Row) : 1;
   localparam int W        = Row * CntBits;

   typedef struct packed {
      logic [RowW-1:0]        row;
      logic [Col*CntBits-1:0] a;
      logic [Col*CntBits-1:0] b;
   } word_t;

   typedef struct {
      logic [ExpWidth-1:0] n;
      logic                sm;
      int                  stall;
      int                  pat;   // 0 fixed pattern, 1 random, 2 no reload
      int                  len;   // expected frameDone cycle
   } vec_t;

   logic readClk = 1'b0;
   logic reset   = 1'b1;

   pixel_readout_ctrl_if #(.Row(Row), .Col(Col), .CntBits(CntBits), .ExpWidth(ExpWidth)) bus ();

   pixel_readout_ctrl #(.Row(Row), .Col(Col), .CntBits(CntBits), .ExpWidth(ExpWidth)) dut (
      .readClk (readClk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 readClk = ~readClk;

   int checks = 0;
   int errors = 0;

   // ---------------- pixel array model ----------------
   logic [CntBits-1:0] pixA [Row][Col];
   logic [CntBits-1:0] pixB [Row][Col];
   logic [W-1:0]       chA [Col];
   logic [W-1:0]       chB [Col];
   logic               do_load = 1'b0;

   // row 0 sits at the chain output, MSB first
   always @(posedge readClk) begin
      for (int c = 0; c < Col; c++) begin
         if (do_load) begin
            for (int r = 0; r < Row; r++) begin
               chA[c][W-1-r*CntBits -: CntBits] <= pixA[r][c];
               chB[c][W-1-r*CntBits -: CntBits] <= pixB[r][c];
            end
         end else if (bus.shiftEn) begin
            chA[c] <= {chA[c][W-2:0], bus.serInA[c]};
            chB[c] <= {chB[c][W-2:0], bus.serInB[c]};
         end
      end
   end

   always_comb begin
      bus.serOutA = '0;
      bus.serOutB = '0;
      for (int c = 0; c < Col; c++) begin
         bus.serOutA[c] = chA[c][W-1];
         bus.serOutB[c] = chB[c][W-1];
      end
   end

   // ---------------- consumer ready driver ----------------
   int ready_mode = 0;   // 0 always ready, 1 stall first word, 2 random
   int stall_left = 0;

   always begin
      @(posedge readClk);
      #2;
      if (ready_mode == 0) begin
         bus.dataReady = 1'b1;
      end else if (ready_mode == 1) begin
         if (bus.dataValid && stall_left > 0) begin
            bus.dataReady = 1'b0;
            stall_left--;
         end else begin
            bus.dataReady = 1'b1;
         end
      end else begin
         bus.dataReady = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- monitor ----------------
   int    cyc = 0, done_cyc = 0;
   int    fe_total = 0, sh_total = 0, done_total = 0;
   int    viol_total = 0, stab_total = 0, sm_total = 0;
   logic  exp_sum = 1'b0;
   logic  m_busy = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
   word_t p_word;
   word_t rx [$];

   always @(negedge readClk) begin
      if (bus.busy && !m_busy) cyc = 1;
      else if (bus.busy) cyc++;
      m_busy = bus.busy;
      if (bus.feReset) fe_total++;
      if (bus.shutter) sh_total++;
      if (bus.frameDone) begin
         done_total++;
         done_cyc = cyc;
      end
      if (bus.dataValid && bus.shiftEn) viol_total++;
      if (bus.busy && bus.sumMode !== exp_sum) sm_total++;
      if (p_valid && !p_ready &&
          (!bus.dataValid || bus.dataRow !== p_word.row ||
           bus.dataA !== p_word.a || bus.dataB !== p_word.b)) stab_total++;
      if (bus.dataValid && bus.dataReady) rx.push_back('{bus.dataRow, bus.dataA, bus.dataB});
      p_valid = bus.dataValid;
      p_ready = bus.dataReady;
      p_word  = '{bus.dataRow, bus.dataA, bus.dataB};
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_quiet(input string pfx);
      check({pfx, "_busy"},      bus.busy,      0);
      check({pfx, "_feReset"},   bus.feReset,   0);
      check({pfx, "_shutter"},   bus.shutter,   0);
      check({pfx, "_sumMode"},   bus.sumMode,   0);
      check({pfx, "_shiftEn"},   bus.shiftEn,   0);
      check({pfx, "_dataValid"}, bus.dataValid, 0);
      check({pfx, "_dataRow"},   bus.dataRow,   0);
      check({pfx, "_dataA"},     bus.dataA,     0);
      check({pfx, "_dataB"},     bus.dataB,     0);
      check({pfx, "_frameDone"}, bus.frameDone, 0);
      check({pfx, "_serIn"},     {bus.serInA, bus.serInB}, 0);
   endtask

   task automatic load_pixels(input int pat);
      for (int r = 0; r < Row; r++) begin
         for (int c = 0; c < Col; c++) begin
            if (pat == 0) begin
               pixA[r][c] = CntBits'(32'hA00 | (r << 4) | c);
               pixB[r][c] = ~pixA[r][c];
            end else begin
               pixA[r][c] = CntBits'($urandom);
               pixB[r][c] = CntBits'($urandom);
            end
         end
      end
      @(negedge readClk);
      do_load = 1'b1;
      @(negedge readClk);
      do_load = 1'b0;
   endtask

   task automatic run_frame(input logic [ExpWidth-1:0] n, input logic sm,
                            input int stall, input int rmode, input int exp_len);
      int d0, f0, s0, v0, st0, m0, k;
      logic [Col*CntBits-1:0] ea, eb;
      @(negedge readClk);
      exp_sum    = sm;
      stall_left = stall;
      ready_mode = rmode;
      rx.delete();
      d0 = done_total; f0 = fe_total; s0 = sh_total;
      v0 = viol_total; st0 = stab_total; m0 = sm_total;
      bus.start      = 1'b1;
      bus.expCycles  = n;
      bus.sumModeCfg = sm;
      @(negedge readClk);
      bus.start     = 1'b0;
      bus.expCycles = ExpWidth'($urandom);
      check("busy_after_start", bus.busy, 1);
      k = 0;
      while (!bus.frameDone && k < 70000) begin
         bus.start      = (bus.shutter || bus.shiftEn) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.sumModeCfg = 1'($urandom_range(0, 1));
         @(negedge readClk);
         k++;
      end
      bus.start = 1'b0;
      check("frame_done_seen", k < 70000, 1);
      repeat (3) @(negedge readClk);
      check("busy_after_done", bus.busy, 0);
      check("done_pulses", done_total - d0, 1);
      check("fe_cycles", fe_total - f0, 2);
      check("shutter_cycles", sh_total - s0, (n == 0) ? 1 : n);
      if (exp_len > 0) check("frame_len", done_cyc, exp_len);
      check("shift_while_valid", viol_total - v0, 0);
      check("word_stable", stab_total - st0, 0);
      check("summode_held", sm_total - m0, 0);
      check("word_count", rx.size(), Row);
      for (int i = 0; i < Row; i++) begin
         if (i < rx.size()) begin
            ea = '0;
            eb = '0;
            for (int c = 0; c < Col; c++) begin
               ea[c*CntBits +: CntBits] = pixA[i][c];
               eb[c*CntBits +: CntBits] = pixB[i][c];
            end
            check("word_row", rx[i].row, i);
            check("word_a", rx[i].a, ea);
            check("word_b", rx[i].b, eb);
         end
      end
      // a full readout leaves only the zero fill in the chains
      for (int r = 0; r < Row; r++) begin
         for (int c = 0; c < Col; c++) begin
            pixA[r][c] = '0;
            pixB[r][c] = '0;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   vec_t vt [5];

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, nsh;
      vt[0] = '{16'd5, 1'b0, 0, 0, 36};
      vt[1] = '{16'd5, 1'b1, 0, 2, 36};
      vt[2] = '{16'd5, 1'b0, 7, 1, 43};
      vt[3] = '{16'd0, 1'b1, 0, 1, 32};
      vt[4] = '{16'd3, 1'b1, 0, 0, 34};

      bus.start      = 1'b0;
      bus.sumModeCfg = 1'b0;
      bus.expCycles  = '0;
      repeat (3) @(negedge readClk);
      reset = 1'b0;
      check_quiet("reset");

      for (int i = 0; i < 5; i++) begin
         if (vt[i].pat != 2) load_pixels(vt[i].pat);
         run_frame(vt[i].n, vt[i].sm, vt[i].stall, 1, vt[i].len);
      end

      for (int i = 0; i < 4; i++) begin
         load_pixels(1);
         run_frame(ExpWidth'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 0, 2, -1);
      end

      load_pixels(1);
      run_frame(16'hFFFF, 1'b0, 0, 0, 65566);

      // reset while the sixth bit of row 0 is being shifted
      load_pixels(0);
      ready_mode = 0;
      @(negedge readClk);
      bus.start      = 1'b1;
      bus.expCycles  = 16'd2;
      bus.sumModeCfg = 1'b1;
      @(negedge readClk);
      bus.start = 1'b0;
      k   = 0;
      nsh = 0;
      while (nsh < 6 && k < 200) begin
         @(negedge readClk);
         if (bus.shiftEn) nsh++;
         k++;
      end
      check("reach_shift_bit5", nsh, 6);
      reset = 1'b1;
      @(negedge readClk);
      check_quiet("abort");
      reset = 1'b0;
      load_pixels(0);
      run_frame(16'd5, 1'b1, 0, 0, 36);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
